// File: rtl/ws2812_pkg.sv
// rtl/ws2812_pkg.sv - colour order encodings, timing defaults and FSM states for the WS2812 driver
package ws2812_pkg;

   localparam logic [1:0] ORDER_GRB = 2'd0;
   localparam logic [1:0] ORDER_RGB = 2'd1;
   localparam logic [1:0] ORDER_BRG = 2'd2;
   localparam logic [1:0] ORDER_RBG = 2'd3;

   localparam int DEF_T0H_CYC   = 35;
   localparam int DEF_T1H_CYC   = 90;
   localparam int DEF_BIT_CYC   = 125;
   localparam int DEF_RESET_CYC = 32768;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LATCH,
      S_BIT_HI,
      S_BIT_LO,
      S_STALL,
      S_DONE
   } state_t;

   // Pixel {W,R,G,B} to an MSB-aligned wire word; W trails the colours in RGBW mode.
   function automatic logic [31:0] reorder(input logic [31:0] pix, input logic [1:0] order,
                                           input logic rgbw);
      logic [7:0]  w, r, g, b;
      logic [23:0] c;
      {w, r, g, b} = pix;
      case (order)
         ORDER_GRB: c = {g, r, b};
         ORDER_RGB: c = {r, g, b};
         ORDER_BRG: c = {b, r, g};
         default:   c = {r, b, g};
      endcase
      return {c, (rgbw ? w : 8'h00)};
   endfunction

endpackage

// File: rtl/ws2812_bit_encoder.sv
// rtl/ws2812_bit_encoder.sv - MSB-first NRZ pulse-width serialiser for one pixel word
module ws2812_bit_encoder #(
   parameter int BPP     = 24,
   parameter int T0H_CYC = 35,
   parameter int T1H_CYC = 90,
   parameter int BIT_CYC = 125
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        load,
   input  logic [31:0] word,
   output logic        TDIN,
   output logic        hi_end,
   output logic        bit_end,
   output logic        word_done
);
   localparam int TW = $clog2(BIT_CYC + 1);
   localparam int BW = $clog2(BPP);
   localparam logic [BW-1:0] LAST_BIT = BW'(BPP - 1);

   logic          hi_q, lo_q;
   logic [TW-1:0] tmr;
   logic [TW-1:0] th, tl;
   logic [BW-1:0] bit_idx;
   logic [31:0]   sh;

   assign th        = sh[31] ? TW'(T1H_CYC) : TW'(T0H_CYC);
   assign tl        = TW'(BIT_CYC) - th;
   assign hi_end    = hi_q && (tmr == th - TW'(1));
   assign bit_end   = lo_q && (tmr == tl - TW'(1));
   assign word_done = bit_end && (bit_idx == LAST_BIT);
   assign TDIN      = hi_q;

   // load wins over word_done so the next pixel starts with no idle cycle
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         hi_q    <= 1'b0;
         lo_q    <= 1'b0;
         tmr     <= '0;
         bit_idx <= '0;
         sh      <= '0;
      end else if (load) begin
         sh      <= word;
         hi_q    <= 1'b1;
         lo_q    <= 1'b0;
         tmr     <= '0;
         bit_idx <= '0;
      end else if (hi_end) begin
         hi_q <= 1'b0;
         lo_q <= 1'b1;
         tmr  <= '0;
      end else if (word_done) begin
         lo_q <= 1'b0;
         tmr  <= '0;
      end else if (bit_end) begin
         sh      <= {sh[30:0], 1'b0};
         bit_idx <= bit_idx + 1'b1;
         hi_q    <= 1'b1;
         lo_q    <= 1'b0;
         tmr     <= '0;
      end else if (hi_q || lo_q) begin
         tmr <= tmr + 1'b1;
      end
   end

endmodule

// File: rtl/ws2812_stream_driver.sv
// rtl/ws2812_stream_driver.sv - WS2812/SK6812 frame driver fed by a pixel valid/ready stream
module ws2812_stream_driver
   import ws2812_pkg::*;
#(
   parameter int LED_MAX   = 16,
   parameter int ADDR_BIT  = $clog2(LED_MAX) + 1,
   parameter int BPP       = 24,
   parameter int T0H_CYC   = DEF_T0H_CYC,
   parameter int T1H_CYC   = DEF_T1H_CYC,
   parameter int BIT_CYC   = DEF_BIT_CYC,
   parameter int RESET_CYC = DEF_RESET_CYC
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                GO,
   input  logic [ADDR_BIT-1:0] LED_CNT,
   input  logic [1:0]          ORDER,
   input  logic [31:0]         PIX_DATA,
   input  logic                PIX_VALID,
   output logic                PIX_READY,
   output logic [ADDR_BIT-1:0] PIX_ADDR,
   output logic                TDIN,
   output logic                BUSY,
   output logic                DONE,
   output logic                UNDERRUN
);
   localparam int CNT_W = $clog2(((BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC) + 1);
   localparam logic [ADDR_BIT-1:0] LED_MAX_A = ADDR_BIT'(LED_MAX);

   state_t              state, state_nx;
   logic                go_q, go_rise;
   logic [CNT_W-1:0]    latch_tmr;
   logic                latch_end;
   logic [ADDR_BIT-1:0] cnt_q;
   logic [1:0]          order_q;
   logic                shadow_full;
   logic [31:0]         shadow;
   logic [31:0]         enc_word;
   logic                fetch_en, take, reload, load;
   logic                hi_end, bit_end, word_done;

   assign go_rise   = GO && !go_q;
   assign latch_end = (state == S_LATCH) && (latch_tmr == CNT_W'(RESET_CYC - 1));
   assign fetch_en  = (state == S_LATCH) || (state == S_BIT_HI) ||
                      (state == S_BIT_LO) || (state == S_STALL);
   assign PIX_READY = fetch_en && !shadow_full && (PIX_ADDR < cnt_q);
   assign take      = PIX_VALID && PIX_READY;
   // points where the shift register wants its next pixel
   assign reload    = latch_end || ((state == S_BIT_LO) && word_done) || (state == S_STALL);
   assign enc_word  = reorder(shadow, order_q, (BPP == 32));

   ws2812_bit_encoder #(
      .BPP    (BPP),
      .T0H_CYC(T0H_CYC),
      .T1H_CYC(T1H_CYC),
      .BIT_CYC(BIT_CYC)
   ) u_enc (
      .CLK      (CLK),
      .RST_N    (RST_N),
      .load     (load),
      .word     (enc_word),
      .TDIN     (TDIN),
      .hi_end   (hi_end),
      .bit_end  (bit_end),
      .word_done(word_done)
   );

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      UNDERRUN = 1'b0;
      DONE     = 1'b0;
      BUSY     = (state != S_IDLE);
      case (state)
         S_IDLE:   if (go_rise) state_nx = S_LATCH;
         S_BIT_HI: if (hi_end) state_nx = S_BIT_LO;
         S_BIT_LO: if (bit_end && !word_done) state_nx = S_BIT_HI;
         S_DONE: begin
            DONE     = 1'b1;
            state_nx = S_IDLE;
         end
         default: ;
      endcase
      // empty shadow with everything fetched means the frame is complete
      if (reload) begin
         if (shadow_full) begin
            load     = 1'b1;
            state_nx = S_BIT_HI;
         end else if (PIX_ADDR == cnt_q) begin
            state_nx = S_DONE;
         end else begin
            state_nx = S_STALL;
            UNDERRUN = (state != S_STALL);
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         go_q        <= 1'b0;
         latch_tmr   <= '0;
         cnt_q       <= '0;
         order_q     <= ORDER_GRB;
         shadow_full <= 1'b0;
         shadow      <= '0;
         PIX_ADDR    <= '0;
      end else begin
         go_q      <= GO;
         latch_tmr <= (state == S_LATCH) ? latch_tmr + 1'b1 : '0;
         if ((state == S_IDLE) && go_rise) begin
            cnt_q   <= (LED_CNT > LED_MAX_A) ? LED_MAX_A : LED_CNT;
            order_q <= ORDER;
         end
         if (take) begin
            shadow      <= PIX_DATA;
            shadow_full <= 1'b1;
            PIX_ADDR    <= PIX_ADDR + 1'b1;
         end else if (load) begin
            shadow_full <= 1'b0;
         end
         if (state == S_DONE) PIX_ADDR <= '0;
      end
   end

endmodule

// File: tb/tb_ws2812_stream_driver.sv
// tb/tb_ws2812_stream_driver.sv - scoreboard bench decoding TDIN back into pixel words
module tb_ws2812_stream_driver;
   localparam int BIT_T   = 10;
   localparam int RESET_T = 20;

   typedef struct {
      int          dly;
      logic [31:0] data;
   } feed_t;

   logic        clk, rst_n, go24, go32, pix_valid, sel32;
   logic [2:0]  led_cnt;
   logic [1:0]  order;
   logic [31:0] pix_data;
   logic        rdy24, tdin24, busy24, done24, und24;
   logic        rdy32, tdin32, busy32, done32, und32;
   logic [2:0]  addr24, addr32;

   int          n_tests = 0;
   int          n_fail  = 0;
   feed_t       feed_q[$];
   logic [31:0] sb_q[$];
   int          exp_cyc;

   ws2812_stream_driver #(.LED_MAX(4), .BPP(24), .T0H_CYC(3), .T1H_CYC(7), .BIT_CYC(10),
                          .RESET_CYC(20)) u_dut24 (
      .CLK(clk), .RST_N(rst_n), .GO(go24), .LED_CNT(led_cnt), .ORDER(order),
      .PIX_DATA(pix_data), .PIX_VALID(pix_valid), .PIX_READY(rdy24), .PIX_ADDR(addr24),
      .TDIN(tdin24), .BUSY(busy24), .DONE(done24), .UNDERRUN(und24));

   ws2812_stream_driver #(.LED_MAX(4), .BPP(32), .T0H_CYC(3), .T1H_CYC(7), .BIT_CYC(10),
                          .RESET_CYC(20)) u_dut32 (
      .CLK(clk), .RST_N(rst_n), .GO(go32), .LED_CNT(led_cnt), .ORDER(order),
      .PIX_DATA(pix_data), .PIX_VALID(pix_valid), .PIX_READY(rdy32), .PIX_ADDR(addr32),
      .TDIN(tdin32), .BUSY(busy32), .DONE(done32), .UNDERRUN(und32));

   logic       mon_tdin, mon_busy, mon_done, mon_und, mon_rdy, go_sel;
   logic [2:0] mon_addr;
   int         mon_bpp;
   assign mon_tdin = sel32 ? tdin32 : tdin24;
   assign mon_busy = sel32 ? busy32 : busy24;
   assign mon_done = sel32 ? done32 : done24;
   assign mon_und  = sel32 ? und32  : und24;
   assign mon_rdy  = sel32 ? rdy32  : rdy24;
   assign mon_addr = sel32 ? addr32 : addr24;
   assign go_sel   = sel32 ? go32   : go24;
   assign mon_bpp  = sel32 ? 32 : 24;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input longint obs, input longint exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_pix(input int dly, input logic [31:0] pix, input logic [31:0] wire_bits);
      feed_t f;
      f.dly  = dly;
      f.data = pix;
      feed_q.push_back(f);
      sb_q.push_back(wire_bits);
   endtask

   // pixel source: each entry waits dly cycles with VALID low, then holds VALID until accepted
   initial begin : feeder
      feed_t cur;
      int    dly_left;
      bit    hs, active;
      int    exp_addr;
      pix_valid = 1'b0;
      pix_data  = '0;
      active    = 0;
      dly_left  = 0;
      exp_addr  = 0;
      forever begin
         @(negedge clk);
         hs = rst_n && pix_valid && mon_rdy;
         if (!rst_n || mon_done) exp_addr = 0;
         else if (hs) begin
            check("pix_addr", mon_addr, exp_addr);
            exp_addr++;
         end
         @(posedge clk);
         #1;
         if (!rst_n) begin
            pix_valid = 1'b0;
            active    = 0;
         end else begin
            if (hs) begin
               pix_valid = 1'b0;
               active    = 0;
            end
            if (!active && feed_q.size() > 0) begin
               cur      = feed_q.pop_front();
               dly_left = cur.dly;
               pix_data = cur.data;
               active   = 1;
            end
            if (active && !pix_valid) begin
               if (dly_left == 0) pix_valid = 1'b1;
               else dly_left--;
            end
         end
      end
   end

   int          hi_len, lo_len, last_hi, nbits, bits_total, latch_len, frame_cyc, und_cnt, rdy_cnt;
   bit          first_hi, stalled, prev_t, prev_go;
   logic [31:0] word;

   always @(negedge clk) begin
      if (!rst_n || (go_sel && !prev_go && !mon_busy)) begin
         hi_len = 0; lo_len = 0; last_hi = 0; nbits = 0; bits_total = 0; latch_len = 0;
         frame_cyc = 0; und_cnt = 0; rdy_cnt = 0; first_hi = 0; stalled = 0; word = '0;
      end
      prev_go = rst_n && go_sel;
      if (rst_n) begin
         if (mon_und) begin
            und_cnt++;
            stalled = 1;
         end
         if (mon_rdy) rdy_cnt++;
         if (mon_done) begin
            if (bits_total > 0) check("last_bit_period", last_hi + lo_len, BIT_T);
            else check("latch_only_gap", latch_len, RESET_T);
            if (exp_cyc >= 0) check("frame_cycles", frame_cyc, exp_cyc);
         end
         if (mon_busy && !mon_done && !first_hi && !mon_tdin) latch_len++;
         if (mon_tdin && !first_hi) begin
            first_hi = 1;
            check("latch_gap", latch_len, RESET_T);
         end
         if (mon_tdin && !prev_t) begin
            if (bits_total > 0 && !stalled) check("bit_period", last_hi + lo_len, BIT_T);
            stalled = 0;
            hi_len  = 0;
         end
         if (mon_tdin) hi_len++;
         if (!mon_tdin && prev_t) begin
            check("bit_high", hi_len, (hi_len > 5) ? 7 : 3);
            word = {word[30:0], (hi_len > 5)};
            nbits++;
            bits_total++;
            last_hi = hi_len;
            lo_len  = 0;
            if (nbits == mon_bpp) begin
               if (sb_q.size() == 0) check("sb_underflow", sb_q.size(), 1);
               else check("pixel_word", word, sb_q.pop_front());
               nbits = 0;
               word  = '0;
            end
         end
         if (!mon_tdin && first_hi) lo_len++;
         if (first_hi && !mon_done) frame_cyc++;
      end
      prev_t = rst_n && mon_tdin;
   end

   task automatic run_frame(input bit use32, input int n, input logic [1:0] ord,
                            input int exp_und, input int exp_cyc_i, input bit repulse);
      int t;
      @(posedge clk);
      #1;
      sel32   = use32;
      led_cnt = 3'(n);
      order   = ord;
      exp_cyc = exp_cyc_i;
      if (use32) go32 = 1'b1;
      else go24 = 1'b1;
      @(posedge clk);
      #1;
      go24 = 1'b0;
      go32 = 1'b0;
      t = 0;
      while (!mon_done && t < 3000) begin
         @(negedge clk);
         t++;
         if (repulse && t == 100) go24 = 1'b1;
         if (repulse && t == 102) go24 = 1'b0;
      end
      check("done_seen", mon_done, 1);
      @(posedge clk);
      #1;
      check("busy_after", mon_busy, 0);
      check("addr_wrap", mon_addr, 0);
      check("underruns", und_cnt, exp_und);
      check("sb_drained", sb_q.size(), 0);
      if (n == 0) check("ready_never", rdy_cnt, 0);
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int t;
      rst_n = 1'b0; go24 = 1'b0; go32 = 1'b0; led_cnt = '0; order = '0; sel32 = 1'b0;
      exp_cyc = -1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_tdin", tdin24, 0);
      check("rst_busy", busy24, 0);
      check("rst_done", done24, 0);
      check("rst_ready", rdy24, 0);
      check("rst_addr", addr24, 0);
      check("rst_underrun", und24, 0);
      check("rst_tdin32", tdin32, 0);
      @(negedge clk);
      rst_n = 1'b1;

      push_pix(0, 32'h00FF0000, 32'h00FF00);
      run_frame(0, 1, 2'd0, 0, 240, 0);

      push_pix(0, 32'h00123456, 32'h123456);
      run_frame(0, 1, 2'd1, 0, 240, 0);
      push_pix(0, 32'h00123456, 32'h561234);
      run_frame(0, 1, 2'd2, 0, 240, 0);

      push_pix(0, 32'hA5000000, 32'h000000A5);
      run_frame(1, 1, 2'd0, 0, 320, 0);

      push_pix(0,   32'h00112233, 32'h113322);
      push_pix(280, 32'h00ABCDEF, 32'hABEFCD);
      push_pix(0,   32'h00800001, 32'h800100);
      run_frame(0, 3, 2'd3, 1, -1, 0);

      push_pix(0, 32'h00000001, 32'h000001);
      run_frame(0, 1, 2'd0, 0, 240, 1);
      run_frame(0, 0, 2'd0, 0, -1, 0);

      // reset while pixel 0 is driving a high pulse
      @(posedge clk);
      #1;
      sel32 = 1'b0; led_cnt = 3'd1; order = 2'd0;
      feed_q.push_back('{dly: 0, data: 32'h00FFFFFF});
      go24 = 1'b1;
      @(posedge clk);
      #1;
      go24 = 1'b0;
      t = 0;
      while (!tdin24 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check("rst_wait_hi", tdin24, 1);
      #1;
      rst_n = 1'b0;
      #1;
      check("midrst_tdin", tdin24, 0);
      check("midrst_busy", busy24, 0);
      feed_q.delete();
      sb_q.delete();
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      push_pix(0, 32'h00C0FFEE, 32'hC0FFEE);
      push_pix(0, 32'h00010203, 32'h010203);
      run_frame(0, 2, 2'd1, 0, 480, 0);

      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
